// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD unit, its requester and benches:
// requester state encoding, default operand width and the input-word packer.
package gcd_pkg;

    localparam int GCD_WIDTH = 16;

    typedef enum logic [2:0] {
        GCDR_IDLE  = 3'd0,
        GCDR_ISSUE = 3'd1,
        GCDR_WAIT  = 3'd2,
        GCDR_RESP  = 3'd3,
        GCDR_DRAIN = 3'd4
    } gcdr_state_e;

    // A sits in the low half of the GCD input word, B in the high half.
    function automatic logic [2*GCD_WIDTH-1:0] gcd_pack(input logic [GCD_WIDTH-1:0] a,
                                                        input logic [GCD_WIDTH-1:0] b);
        return {b, a};
    endfunction

endpackage

// File: rtl/gcd_requester.sv
// Host-side initiator for the GCD unit: issues one operand pair at a time, captures the
// unbuffered result pulse, returns it with backpressure, and recovers from hung requests.
module gcd_requester
    import gcd_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               io_req_valid,
    input  logic [WIDTH-1:0]   io_req_a,
    input  logic [WIDTH-1:0]   io_req_b,
    output logic               io_req_ready,
    output logic               io_resp_valid,
    output logic [WIDTH-1:0]   io_resp_data,
    output logic               io_resp_timeout,
    input  logic               io_resp_ready,
    output logic               io_gcd_in_valid,
    output logic [2*WIDTH-1:0] io_gcd_in_data,
    input  logic               io_gcd_in_ready,
    input  logic               io_gcd_out_valid,
    input  logic [WIDTH-1:0]   io_gcd_out_data,
    output logic [15:0]        io_done_count,
    output logic [7:0]         io_timeout_count
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // valid and its payload hold until that edge. The GCD result pulse has no ready.
    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    gcdr_state_e      state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] resp_data_q, resp_data_d;
    logic             resp_timeout_q, resp_timeout_d;
    logic             drain_q, drain_d;
    logic             stale_seen_q, stale_seen_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [15:0]      done_count_q, done_count_d;
    logic [7:0]       timeout_count_q, timeout_count_d;
    logic             req_ready_q, req_ready_d;

    always_comb begin
        state_d         = state_q;
        a_d             = a_q;
        b_d             = b_q;
        resp_data_d     = resp_data_q;
        resp_timeout_d  = resp_timeout_q;
        drain_d         = drain_q;
        stale_seen_d    = stale_seen_q;
        timer_d         = timer_q;
        done_count_d    = done_count_q;
        timeout_count_d = timeout_count_q;
        case (state_q)
            GCDR_IDLE: begin
                if (io_req_valid) begin
                    a_d = io_req_a;
                    b_d = io_req_b;
                    // The GCD unit never finishes with A==0, so answer B directly.
                    if (io_req_a == '0) begin
                        resp_data_d    = io_req_b;
                        resp_timeout_d = 1'b0;
                        state_d        = GCDR_RESP;
                    end else begin
                        state_d = GCDR_ISSUE;
                    end
                end
            end
            GCDR_ISSUE: begin
                if (io_gcd_in_ready) begin
                    timer_d = '0;
                    state_d = GCDR_WAIT;
                end
            end
            GCDR_WAIT: begin
                timer_d = timer_q + 1'b1;
                if (io_gcd_out_valid) begin
                    resp_data_d    = io_gcd_out_data;
                    resp_timeout_d = 1'b0;
                    state_d        = GCDR_RESP;
                end else if (timer_q == TIMER_LAST) begin
                    resp_data_d    = '0;
                    resp_timeout_d = 1'b1;
                    drain_d        = 1'b1;
                    stale_seen_d   = 1'b0;
                    state_d        = GCDR_RESP;
                end
            end
            GCDR_RESP: begin
                if (drain_q && io_gcd_out_valid) begin
                    stale_seen_d = 1'b1;
                end
                if (io_resp_ready) begin
                    if (resp_timeout_q) begin
                        if (timeout_count_q != 8'hFF) begin
                            timeout_count_d = timeout_count_q + 8'd1;
                        end
                    end else begin
                        done_count_d = done_count_q + 16'd1;
                    end
                    // A late result already seen here (or this cycle) settles the drain.
                    if (drain_q && !(stale_seen_q || io_gcd_out_valid)) begin
                        state_d = GCDR_DRAIN;
                    end else begin
                        drain_d      = 1'b0;
                        stale_seen_d = 1'b0;
                        state_d      = GCDR_IDLE;
                    end
                end
            end
            GCDR_DRAIN: begin
                if (io_gcd_out_valid) begin
                    drain_d = 1'b0;
                    state_d = GCDR_IDLE;
                end
            end
            default: state_d = GCDR_IDLE;
        endcase
        req_ready_d = (state_d == GCDR_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= GCDR_IDLE;
            a_q             <= '0;
            b_q             <= '0;
            resp_data_q     <= '0;
            resp_timeout_q  <= 1'b0;
            drain_q         <= 1'b0;
            stale_seen_q    <= 1'b0;
            timer_q         <= '0;
            done_count_q    <= '0;
            timeout_count_q <= '0;
            req_ready_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            a_q             <= a_d;
            b_q             <= b_d;
            resp_data_q     <= resp_data_d;
            resp_timeout_q  <= resp_timeout_d;
            drain_q         <= drain_d;
            stale_seen_q    <= stale_seen_d;
            timer_q         <= timer_d;
            done_count_q    <= done_count_d;
            timeout_count_q <= timeout_count_d;
            req_ready_q     <= req_ready_d;
        end
    end

    // req_ready is its own register so it can read 0 while reset is held.
    assign io_req_ready     = req_ready_q;
    assign io_resp_valid    = (state_q == GCDR_RESP);
    assign io_resp_data     = resp_data_q;
    assign io_resp_timeout  = resp_timeout_q;
    assign io_gcd_in_valid  = (state_q == GCDR_ISSUE);
    assign io_done_count    = done_count_q;
    assign io_timeout_count = timeout_count_q;

    if (WIDTH == GCD_WIDTH) begin : g_pack
        assign io_gcd_in_data = gcd_pack(a_q, b_q);
    end else begin : g_concat
        assign io_gcd_in_data = {b_q, a_q};
    end

endmodule

// File: doc/gcd_requester.md
# gcd_requester

Initiator-side companion to the GCD unit. It accepts operand pairs from a host-side request stream, packs them into the GCD unit's 32-bit input word, and drives that unit's valid/ready input port. It then captures the single-cycle `out_valid` result pulse, which has no backpressure, and returns the result on a host-side response stream that does have backpressure. It also adds zero-operand short-circuiting, a response timeout with stale-result draining, and completion/timeout counters.

## Interface
- `WIDTH`, 16, operand/result width; GCD input word is `2*WIDTH`.
- `TIMEOUT`, 1024, max cycles in WAIT before a timeout response; must be ≥2.
- `clk`  in  1  clock; all logic on posedge.
- `reset`  in  1  synchronous, active-high.
- `io_req_valid`  in  1  host request valid.
- `io_req_a`  in  WIDTH  operand A.
- `io_req_b`  in  WIDTH  operand B.
- `io_req_ready`  out  1  request accepted when valid&ready.
- `io_resp_valid`  out  1  response valid.
- `io_resp_data`  out  WIDTH  GCD result; 0 on timeout.
- `io_resp_timeout`  out  1  response is a timeout.
- `io_resp_ready`  in  1  host accepts response.
- `io_gcd_in_valid`  out  1  to GCD `io_in_valid`.
- `io_gcd_in_data`  out  2*WIDTH  to GCD `io_in_data`: `{b, a}`, so A is in `[WIDTH-1:0]`.
- `io_gcd_in_ready`  in  1  from GCD `io_in_ready`.
- `io_gcd_out_valid`  in  1  from GCD; one-cycle pulse.
- `io_gcd_out_data`  in  WIDTH  from GCD.
- `io_done_count`  out  16  completed non-timeout responses; wraps.
- `io_timeout_count`  out  8  timeout responses; saturates at 255.

## Operation
- States: IDLE, ISSUE, WAIT, RESP, DRAIN. Reset enters IDLE.
- IDLE:
  - `io_req_ready`=1 (decoded from state only).
  - On handshake, latch A and B.
  - If A==0, go to RESP with data=B, timeout=0, no GCD transaction. This is required because the GCD unit never terminates when A==0 and B≠0.
  - Otherwise go to ISSUE.
- ISSUE:
  - `io_gcd_in_valid`=1; data is `{B,A}` from the latched registers.
  - On `io_gcd_in_ready`, go to WAIT and clear the timer.
  - No timeout applies in ISSUE.
- WAIT:
  - Timer increments each cycle.
  - `io_gcd_out_valid` captures `io_gcd_out_data` and goes to RESP with timeout=0.
  - Otherwise, when timer==TIMEOUT-1, go to RESP with data=0, timeout=1, and set the drain flag.
  - If `out_valid` and the timeout hit in the same cycle, the result wins.
- RESP:
  - `io_resp_valid`=1; data and timeout come from registers and are stable until accepted.
  - On `io_resp_ready`: increment `done_count` (or `timeout_count`), then go to DRAIN if the drain flag is set, else IDLE.
- DRAIN:
  - Wait for one `io_gcd_out_valid`, discard it, clear the drain flag, go to IDLE.
  - A late pulse that arrives during RESP already counts toward draining. Track it with a `stale_seen` bit and skip DRAIN.
- `io_gcd_out_valid` in IDLE or ISSUE is ignored.
- Reset values:
  - `io_req_ready`=0 during reset, 1 the cycle after.
  - All other outputs are 0; counters are 0; flags are cleared.
- Reset mid-operation abandons the transaction with no response. The GCD unit shares `reset`, so no drain is needed.

## Timing
- Request handshake at cycle 0 → `io_gcd_in_valid` at cycle 1.
- GCD accept at cycle k → WAIT from k+1.
- `out_valid` at cycle m → `io_resp_valid` at m+1.
- A==0 path: handshake at 0 → `io_resp_valid` at 1.
- With `io_resp_ready` held high, response at n → next `io_req_ready` at n+1. One transaction is outstanding at a time.
- Timeout response asserts exactly TIMEOUT cycles after entering WAIT.
- All outputs are registered or decoded from state only. There is no combinational path from any input to any output.

## Structure
- Shared package `gcd_pkg`:
  - state enum (`GCDR_IDLE`…`GCDR_DRAIN`);
  - `GCD_WIDTH`=16;
  - a `{b,a}` pack function shared with the GCD wrapper and bench.
- No sub-module is needed beyond an inline timer. The counters could be a generic `sat_counter` if one already exists.

## Test plan
- Request (12,18) against a real GCD → `io_gcd_in_data`=0x0012000C, response data=6, timeout=0, `done_count`=1.
- Request (0,7) → response data=7 at cycle 1, `io_gcd_in_valid` never asserted.
- Request (7,0) → issued to the GCD, response data=7.
- Hold `io_resp_ready`=0 for 10 cycles after the result → `resp_valid`/`data` stable, `io_req_ready`=0 throughout, request accepted the cycle after the resp handshake.
- Stub GCD with `out_valid` delayed to cycle TIMEOUT+5, TIMEOUT=16 → timeout response at WAIT+16, late pulse discarded, next request (9,6) returns 3, `timeout_count`=1.
- Assert `reset` mid-WAIT → next cycle all outputs 0 and counters 0; a new request (8,12) returns 4.
